multicycle_sequencer: RTL
=========================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter ALUOP_W, default 3: ALU operation code width, minimum 3.
REQ-002 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-003 Parameter WAIT_EN, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 op  in  6  instruction opcode field from the IR.
REQ-007 funct  in  6  instruction funct field from the IR; only JR (op 000000, funct 001000) is decoded here.
REQ-008 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-009 Outputs pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, alu_src_a, reg_write, illegal_op: each 1 bit.
REQ-010 Outputs pc_source, alu_src_b, memtoreg, reg_dst: each 2 bits; alu_op: ALUOP_W bits.
REQ-011 Output state, 16 bits: one-hot current state.
REQ-012 Output instr_count, CNT_W bits: retired-instruction count.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR and TRAP; one-hot encoded, with IDLE = all zeros.
REQ-014 All control outputs SHALL be a combinational (Moore) function of the registered state, except the mem_ready qualification in REQ-016; every output not listed for a state is 0.
REQ-015 Transitions:
- IDLE -> FETCH.
- FETCH -> DECODE on mem_ready, else hold.
- DECODE dispatches on op:
  - LW (100011) or SW (101011) -> MEM_ADDR.
  - 000000 with funct 001000 -> JR; other 000000 -> R_EXEC.
  - ADDI/SLTI/ANDI/ORI/XORI/LUI (001000/001010/001100/001101/001110/001111) -> I_EXEC.
  - BEQ/BNE (000100/000101) -> BRANCH.
  - J (000010) -> JUMP; JAL (000011) -> JAL.
  - any other op -> TRAP.
- MEM_ADDR -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD -> MEM_WB on mem_ready, else hold.
- MEM_WR -> FETCH on mem_ready, else hold.
- R_EXEC -> R_WB; I_EXEC -> I_WB.
- MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR -> FETCH.
- TRAP holds until reset.
- Any non-one-hot state -> FETCH.
REQ-016 FETCH: mem_read=1, alu_src_b=01, alu_op=0; ir_write and pc_write = mem_ready.
REQ-017 DECODE: alu_src_b=11, alu_op=0.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0.
REQ-019 MEM_RD: iord=1, mem_read=1.
REQ-020 MEM_WB: reg_write=1, memtoreg=01, reg_dst=00.
REQ-021 MEM_WR: iord=1, mem_write=1.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=2.
REQ-023 R_WB: reg_write=1, reg_dst=01, memtoreg=00.
REQ-024 I_EXEC: alu_src_a=1, alu_src_b=10; alu_op (zero-extended to ALUOP_W) = ADDI 3, ANDI 4, ORI 5, XORI 6, SLTI 7, LUI 3 when ALUOP_W=3 and 8 when ALUOP_W>3; op is sampled from the input in that state.
REQ-025 I_WB: reg_write=1, reg_dst=00, memtoreg=00.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1, pc_source=01; pc_write_cond_eq=1 for BEQ, pc_write_cond_ne=1 for BNE.
REQ-027 JUMP: pc_write=1, pc_source=10.
REQ-028 JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, memtoreg=10.
REQ-029 JR: pc_write=1, pc_source=11.
REQ-030 TRAP: illegal_op=1; all other control outputs 0.
REQ-031 instr_count SHALL increment by 1, wrapping modulo 2^CNT_W, on each clock edge leaving MEM_WB, MEM_WR (with mem_ready), R_WB, I_WB, BRANCH, JUMP, JAL or JR.

Reset
REQ-032 Reset low SHALL force state=IDLE and instr_count=0 immediately, regardless of the clock, including mid-wait in any memory state; all control outputs are then 0.
REQ-033 The first rising clock edge after reset deasserts SHALL move the sequencer IDLE -> FETCH.

Structure
REQ-034 State one-hot constants, opcode/funct constants and ALU-op codes SHALL live in shared package mcpu_pkg.
REQ-035 The opcode-to-alu_op mapping SHALL be a sub-module, imm_alu_decode (op, ALUOP_W) -> alu_op, reusable by the pipelined core.

Verification
REQ-036 Run with WAIT_EN=1 throughout; only the fourth scenario below also uses WAIT_EN=0.
- ADDI: mem_ready held 0 for 3 cycles then 1 -> FETCH persists 4 cycles; ir_write=1 only on the fourth; DECODE, I_EXEC with alu_op=3, then I_WB with reg_write=1; instr_count 0->1.
- LW, mem_ready=1: sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, 5 cycles; memtoreg=01 in MEM_WB.
- BNE: BRANCH shows pc_write_cond_ne=1, pc_write_cond_eq=0, pc_source=01, alu_op=1.
- JAL, then op 111111 with WAIT_EN=0: JAL shows reg_dst=10, memtoreg=10, pc_write=1; the next instruction reaches TRAP with illegal_op=1 held for 10 cycles.
- Reset low mid MEM_WR: state=IDLE and instr_count=0 asynchronously; mem_write drops the same cycle.
- CNT_W=4: 16 R-type instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle control unit: one-hot states, MIPS
// opcode/funct fields and ALU operation codes.
package mcpu_pkg;

    typedef enum logic [15:0] {
        S_IDLE     = 16'h0000,
        S_FETCH    = 16'h0001,
        S_DECODE   = 16'h0002,
        S_MEM_ADDR = 16'h0004,
        S_MEM_RD   = 16'h0008,
        S_MEM_WB   = 16'h0010,
        S_MEM_WR   = 16'h0020,
        S_R_EXEC   = 16'h0040,
        S_R_WB     = 16'h0080,
        S_I_EXEC   = 16'h0100,
        S_I_WB     = 16'h0200,
        S_BRANCH   = 16'h0400,
        S_JUMP     = 16'h0800,
        S_JAL      = 16'h1000,
        S_JR       = 16'h2000,
        S_TRAP     = 16'h4000
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam int unsigned ALU_ADD   = 0;
    localparam int unsigned ALU_SUB   = 1;
    localparam int unsigned ALU_RTYPE = 2;
    localparam int unsigned ALU_ADDI  = 3;
    localparam int unsigned ALU_ANDI  = 4;
    localparam int unsigned ALU_ORI   = 5;
    localparam int unsigned ALU_XORI  = 6;
    localparam int unsigned ALU_SLTI  = 7;
    localparam int unsigned ALU_LUI   = 8;

endpackage

// File: rtl/imm_alu_decode.sv
// Maps an I-type opcode to its ALU operation code; shared with the pipelined core.
module imm_alu_decode
    import mcpu_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  logic [5:0]         op,
    output logic [ALUOP_W-1:0] alu_op
);

    // A 3-bit ALU op field has no room for a dedicated LUI code, so LUI rides on ADD.
    localparam int unsigned LUI_CODE = (ALUOP_W > 3) ? ALU_LUI : ALU_ADDI;

    always_comb begin
        alu_op = '0;
        case (op)
            OP_ADDI: alu_op = ALUOP_W'(ALU_ADDI);
            OP_ANDI: alu_op = ALUOP_W'(ALU_ANDI);
            OP_ORI:  alu_op = ALUOP_W'(ALU_ORI);
            OP_XORI: alu_op = ALUOP_W'(ALU_XORI);
            OP_SLTI: alu_op = ALUOP_W'(ALU_SLTI);
            OP_LUI:  alu_op = ALUOP_W'(LUI_CODE);
            default: alu_op = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS-subset control FSM: one-hot Moore state machine driving the
// datapath controls, plus a retired-instruction counter.
module multicycle_sequencer
    import mcpu_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned WAIT_EN = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond_eq,
    output logic               pc_write_cond_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               alu_src_a,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         memtoreg,
    output logic [1:0]         reg_dst,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [15:0]        state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             state_q;
    state_t             state_d;
    logic               retire;
    logic               ready;
    logic [ALUOP_W-1:0] imm_alu_op;
    logic [CNT_W-1:0]   count_q;

    assign ready = (WAIT_EN != 0) ? mem_ready : 1'b1;

    imm_alu_decode #(.ALUOP_W(ALUOP_W)) u_imm_alu_decode (
        .op     (op),
        .alu_op (imm_alu_op)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        alu_src_a        = 1'b0;
        reg_write        = 1'b0;
        illegal_op       = 1'b0;
        pc_source        = 2'b00;
        alu_src_b        = 2'b00;
        memtoreg         = 2'b00;
        reg_dst          = 2'b00;
        alu_op           = '0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_W'(ALU_ADD);
                ir_write  = ready;
                pc_write  = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(ALU_ADD);
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = (funct == FUNCT_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:
                                    state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_W'(ALU_ADD);
                state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                memtoreg  = 2'b01;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_RTYPE);
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALUOP_W'(ALU_SUB);
                pc_source        = 2'b01;
                pc_write_cond_eq = (op == OP_BEQ);
                pc_write_cond_ne = (op == OP_BNE);
                retire           = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                reg_write = 1'b1;
                reg_dst   = 2'b10;
                memtoreg  = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                state_d    = S_TRAP;
            end
            // Corrupted (non-one-hot) state recovers by refetching.
            default: state_d = S_FETCH;
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule
